// File: rtl/systolic_feeder.sv
// systolic_feeder: operand transmitter for an N x N systolic MAC array.
// Buffers one A and one B matrix and streams them into the array edges with
// diagonal skew and zero padding. Every output is registered.
// Build option: define SYSTOLIC_FEEDER_AUTO_CLR_EN to insert a one-cycle
// CLEAR state that pulls pe_clr_no low before each run; without it the
// array accumulates across runs and pe_clr_no is tied high.
module systolic_feeder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic                    wr_sel_i,
  input  logic [$clog2(N)-1:0]    wr_row_i,
  input  logic [$clog2(N)-1:0]    wr_col_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pe_clr_no,
  output logic [N*DATA_WIDTH-1:0] a_o,
  output logic [N*DATA_WIDTH-1:0] b_o
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned SW = $clog2(3*N);
  localparam logic [SW-1:0] LAST_STEP = SW'(3*N-3);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t                  state, state_nx;
  logic [SW-1:0]           step, step_nx;
  logic [DATA_WIDTH-1:0]   a_buf    [N][N];
  logic [DATA_WIDTH-1:0]   b_buf    [N][N];
  logic [DATA_WIDTH-1:0]   a_buf_nx [N][N];
  logic [DATA_WIDTH-1:0]   b_buf_nx [N][N];
  logic [N*DATA_WIDTH-1:0] a_nx, b_nx;
  logic                    busy_nx, done_nx;
  int unsigned             t;

  // Buffer write path; lanes read the post-write view so a write issued
  // alongside start is already visible in the first feed cycle.
  always_comb begin
    a_buf_nx = a_buf;
    b_buf_nx = b_buf;
    if (state == IDLE && wr_en_i) begin
      if (wr_sel_i) b_buf_nx[wr_row_i][wr_col_i] = wr_data_i;
      else          a_buf_nx[wr_row_i][wr_col_i] = wr_data_i;
    end
  end

  // Next-state and feed-step sequencing.
  always_comb begin
    state_nx = state;
    step_nx  = step;
    case (state)
      IDLE: begin
        step_nx = '0;
        if (start_i) begin
`ifdef SYSTOLIC_FEEDER_AUTO_CLR_EN
          state_nx = CLEAR;
`else
          state_nx = FEED;
`endif
        end
      end
      CLEAR: begin
        state_nx = FEED;
        step_nx  = '0;
      end
      FEED: begin
        if (step == LAST_STEP) begin
          state_nx = DONE;
          step_nx  = '0;
        end else begin
          step_nx = step + SW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state and step.
  always_comb begin
    a_nx    = '0;
    b_nx    = '0;
    t       = 32'(step_nx);
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
    if (state_nx == FEED) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (t >= i && t - i < N) begin
          a_nx[i*DATA_WIDTH +: DATA_WIDTH] = a_buf_nx[IW'(i)][IW'(t - i)];
          b_nx[i*DATA_WIDTH +: DATA_WIDTH] = b_buf_nx[IW'(t - i)][IW'(i)];
        end
      end
    end
  end

  // State, step and operand buffers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      step  <= '0;
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
      end
    end else begin
      state <= state_nx;
      step  <= step_nx;
      a_buf <= a_buf_nx;
      b_buf <= b_buf_nx;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_o    <= '0;
      b_o    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      a_o    <= a_nx;
      b_o    <= b_nx;
      busy_o <= busy_nx;
      done_o <= done_nx;
    end
  end

`ifdef SYSTOLIC_FEEDER_AUTO_CLR_EN
  // Array clear is asserted for the whole CLEAR cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) pe_clr_no <= 1'b1;
    else         pe_clr_no <= (state_nx != CLEAR);
  end
`else
  assign pe_clr_no = 1'b1;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder: randomized and directed runs, scoreboard of
// expected lane records, plus a behavioural PE array fed by the DUT lanes
// whose accumulators are compared with A*B at each done pulse.
module tb_systolic_feeder;

  localparam int unsigned N     = 2;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = $clog2(N);
  localparam int unsigned LANES = N*DW;
`ifdef SYSTOLIC_FEEDER_AUTO_CLR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int LAT = AUTO ? 3*N : 3*N-1;

  typedef logic [2*DW+7:0] acc_t;
  typedef struct {
    logic [LANES-1:0] a;
    logic [LANES-1:0] b;
    logic             clr_n;
    logic             done;
  } rec_t;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             wr_en_i, wr_sel_i, start_i;
  logic [IW-1:0]    wr_row_i, wr_col_i;
  logic [DW-1:0]    wr_data_i;
  logic             busy_o, done_o, pe_clr_no;
  logic [LANES-1:0] a_o, b_o;

  systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
    .wr_row_i(wr_row_i), .wr_col_i(wr_col_i), .wr_data_i(wr_data_i),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .pe_clr_no(pe_clr_no),
    .a_o(a_o), .b_o(b_o)
  );

  always #5 clk_i = ~clk_i;

  rec_t          q[$];
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  acc_t          expc [N][N];
  acc_t          acc  [N][N];
  logic [DW-1:0] ad   [N][N];
  logic [DW-1:0] bd   [N][N];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            start_cyc = 0;
  bit            mon_en   = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_array_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc[i][j] = '0; ad[i][j] = '0; bd[i][j] = '0;
      end
  endtask

  // Behavioural array plus scoreboard monitor.
  always @(negedge clk_i) begin : mon
    rec_t r;
    if (mon_en) begin
      // PE(i,j) sees row lane i delayed by j and column lane j delayed by i.
      if (!pe_clr_no) clear_array_model();
      else begin
        for (int d = N-1; d > 0; d--)
          for (int l = 0; l < N; l++) begin
            ad[d][l] = ad[d-1][l];
            bd[d][l] = bd[d-1][l];
          end
        for (int l = 0; l < N; l++) begin
          ad[0][l] = a_o[l*DW +: DW];
          bd[0][l] = b_o[l*DW +: DW];
        end
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc[i][j] += acc_t'(ad[j][i]) * acc_t'(bd[i][j]);
      end
      if (busy_o) begin
        if (q.size() == 0) chk("unexpected_busy", 1, 0);
        else begin
          r = q.pop_front();
          chk("a_lanes", a_o, r.a);
          chk("b_lanes", b_o, r.b);
          chk("pe_clr_n", pe_clr_no, r.clr_n);
          chk("done", done_o, r.done);
          if (r.done) begin
            chk("latency", cyc - start_cyc + 1, LAT);
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++)
                chk($sformatf("c_%0d_%0d", i, j), acc[i][j], expc[i][j]);
          end
        end
      end else begin
        chk("idle_outputs", {a_o == '0, b_o == '0, done_o, pe_clr_no, q.size() == 0},
            5'b11011);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_run();
    rec_t r;
    acc_t p;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        p = '0;
        for (int k = 0; k < N; k++) p += acc_t'(ma[i][k]) * acc_t'(mb[k][j]);
        expc[i][j] = AUTO ? p : expc[i][j] + p;
      end
    if (AUTO) begin
      r.a = '0; r.b = '0; r.clr_n = 1'b0; r.done = 1'b0;
      q.push_back(r);
    end
    for (int t = 0; t <= 3*N-3; t++) begin
      r.a = '0; r.b = '0; r.clr_n = 1'b1; r.done = 1'b0;
      for (int i = 0; i < N; i++)
        if (t >= i && t - i < N) begin
          r.a[i*DW +: DW] = ma[i][t-i];
          r.b[i*DW +: DW] = mb[t-i][i];
        end
      q.push_back(r);
    end
    r.a = '0; r.b = '0; r.clr_n = 1'b1; r.done = 1'b1;
    q.push_back(r);
  endtask

  task automatic set_wr(bit sel, int r, int c, logic [DW-1:0] d);
    wr_en_i = 1'b1; wr_sel_i = sel;
    wr_row_i = IW'(r); wr_col_i = IW'(c); wr_data_i = d;
  endtask

  task automatic model_wr(bit sel, int r, int c, logic [DW-1:0] d);
    if (sel) mb[r][c] = d; else ma[r][c] = d;
  endtask

  task automatic wr(bit sel, int r, int c, logic [DW-1:0] d);
    set_wr(sel, r, c, d);
    tick();
    wr_en_i = 1'b0;
    model_wr(sel, r, c, d);
  endtask

  task automatic start_run(bit hold);
    start_i = 1'b1;
    tick();
    start_cyc = cyc;
    push_run();
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q.size() != 0 || busy_o) && k < 200) begin
      tick();
      k++;
    end
    chk("run_timeout", k < 200, 1);
    tick();
  endtask

  task automatic check_reset_outputs();
    chk("rst_a", a_o, '0);
    chk("rst_b", b_o, '0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_clr_n", pe_clr_no, 1);
  endtask

  function automatic logic [DW-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return $urandom;
      default: return DW'($urandom_range(0, 1000));
    endcase
  endfunction

  initial begin
    rst_ni = 1'b0; wr_en_i = 1'b0; wr_sel_i = 1'b0; start_i = 1'b0;
    wr_row_i = '0; wr_col_i = '0; wr_data_i = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = '0; mb[i][j] = '0; expc[i][j] = '0;
      end
    clear_array_model();
    repeat (2) tick();
    check_reset_outputs();
    rst_ni = 1'b1;
    mon_en = 1'b1;
    tick();

    // Buffers come out of reset zeroed.
    start_run(0);
    wait_idle();

    // A=[[1,2],[3,4]], B=[[5,6],[7,8]].
    wr(0, 0, 0, 1); wr(0, 0, 1, 2); wr(0, 1, 0, 3); wr(0, 1, 1, 4);
    wr(1, 0, 0, 5); wr(1, 0, 1, 6); wr(1, 1, 0, 7); wr(1, 1, 1, 8);
    start_run(0);
    wait_idle();
    if (AUTO) chk("c_test1_11", expc[1][1], 50);

    // Rewrite only the changed elements: A becomes identity.
    wr(0, 0, 1, 0); wr(0, 1, 0, 0); wr(0, 1, 1, 1);
    start_run(0);
    wait_idle();

    // start held high and writes during the run are ignored.
    start_run(1);
    repeat (2) begin
      set_wr(0, 0, 0, 32'hDEAD);
      tick();
      set_wr(1, 1, 1, 32'hBEEF);
      tick();
    end
    wr_en_i = 1'b0;
    begin
      int k = 0;
      while (!done_o && k < 50) begin tick(); k++; end
      chk("done_seen_hold", done_o, 1);
    end
    start_i = 1'b0;
    wait_idle();
    start_run(0);
    wait_idle();

    // Write and start in the same cycle: run uses the new value.
    set_wr(1, 0, 1, 9);
    start_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
    start_i = 1'b0;
    model_wr(1, 0, 1, 9);
    start_cyc = cyc;
    push_run();
    wait_idle();

    // Reset at FEED t=1 aborts the run without a done pulse.
    start_run(0);
    repeat (AUTO ? 2 : 1) tick();
    rst_ni = 1'b0;
    tick();
    q.delete();
    clear_array_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = '0; mb[i][j] = '0; expc[i][j] = '0;
      end
    check_reset_outputs();
    rst_ni = 1'b1;
    tick();
    wr(0, 0, 0, 1); wr(0, 0, 1, 2); wr(0, 1, 0, 3); wr(0, 1, 1, 4);
    wr(1, 0, 0, 5); wr(1, 0, 1, 6); wr(1, 1, 0, 7); wr(1, 1, 1, 8);
    start_run(0);
    wait_idle();
    start_run(0);
    wait_idle();
    if (!AUTO) chk("c_accum_11", expc[1][1], 100);

    // Randomized runs: partial rewrites, random gaps.
    for (int run = 0; run < 10; run++) begin
      int nw = $urandom_range(1, 2*N*N);
      for (int w = 0; w < nw; w++)
        wr(1'($urandom_range(0, 1)), $urandom_range(0, N-1), $urandom_range(0, N-1), rnd_val());
      repeat ($urandom_range(0, 3)) tick();
      start_run(0);
      wait_idle();
    end

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
